// File: rtl/ram_scan_pkg.sv
// rtl/ram_scan_pkg.sv - shared state encoding and size defaults for the RAM scan reader
package ram_scan_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } scan_state_t;

endpackage

// File: rtl/ram_scan_reader.sv
// rtl/ram_scan_reader.sv - walks a synchronous RAM from start_addr for count words, handing each out with valid/ready
module ram_scan_reader
  import ram_scan_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_q,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_WORD  = {{ADDR_W{1'b0}}, 1'b1};

  scan_state_t       state;
  logic [ADDR_W:0]   remaining;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ram_addr  <= '0;
      out_data  <= '0;
      out_addr  <= '0;
      remaining <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && (count != '0)) begin
            ram_addr  <= start_addr;
            remaining <= (count > MAX_WORDS) ? MAX_WORDS : count;
            busy      <= 1'b1;
            state     <= ADDR;
          end
        end
        // RAM registers ram_addr on this edge; q is valid during WAIT
        ADDR: state <= WAIT;
        WAIT: begin
          out_data  <= ram_q;
          out_addr  <= ram_addr;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (remaining > ONE_WORD) begin
              remaining <= remaining - ONE_WORD;
              ram_addr  <= ram_addr + ADDR_W'(1);
              state     <= ADDR;
            end else begin
              remaining <= '0;
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_scan_reader.sv
// tb/tb_ram_scan_reader.sv - scoreboard bench for ram_scan_reader paired with a 32x4 registered-address RAM model
module tb_ram_scan_reader;

  localparam int AW = 5;
  localparam int DW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   count = '0;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_q;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          busy;
  logic          done;

  ram_scan_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset), .start(start), .start_addr(start_addr),
    .count(count), .ram_addr(ram_addr), .ram_q(ram_q), .out_data(out_data),
    .out_addr(out_addr), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // ram32x4 behaviour: address registered, q combinational from the stored address
  logic [DW-1:0] mem [32];
  logic [AW-1:0] ram_addr_q = '0;
  always @(posedge clock) ram_addr_q <= ram_addr;
  assign ram_q = mem[ram_addr_q];

  typedef struct { int addr; int data; } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_acc = -1;
  int scan_start_cyc = 0;
  bit gap_en = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    exp_t e;
    if (done) done_cnt++;
    if (out_valid && out_ready && !reset) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("out_addr", int'(out_addr), e.addr);
        check("out_data", int'(out_data), e.data);
      end
      if (gap_en && last_acc > scan_start_cyc) check("word_gap", cyc - last_acc, 3);
      last_acc = cyc;
    end
  end

  task automatic start_scan(input int sa, input int cnt);
    int n;
    exp_t e;
    n = (cnt > 32) ? 32 : cnt;
    for (int i = 0; i < n; i++) begin
      e.addr = (sa + i) % 32;
      e.data = e.addr % 16;
      exp_q.push_back(e);
    end
    @(posedge clock);
    #1;
    start = 1'b1;
    start_addr = AW'(sa);
    count = (AW+1)'(cnt);
    scan_start_cyc = cyc;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clock);
      if (done) seen = 1'b1;
    end
    check(tag, int'(seen), 1);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    @(negedge clock);
    check({tag, "_done_one_cycle"}, int'(done), 0);
    check({tag, "_busy_low"}, int'(busy), 0);
  endtask

  initial begin
    int d0;
    bit seen;
    logic [DW-1:0] hold_d;
    logic [AW-1:0] hold_a;

    for (int i = 0; i < 32; i++) mem[i] = DW'(i % 16);

    repeat (3) @(negedge clock);
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_done", int'(done), 0);
    check("rst_ram_addr", int'(ram_addr), 0);
    check("rst_out_addr", int'(out_addr), 0);
    check("rst_out_data", int'(out_data), 0);
    reset = 1'b0;

    // basic scan with latency and throughput
    out_ready = 1'b1;
    gap_en = 1'b1;
    start_scan(3, 4);
    check("busy_after_start", int'(busy), 1);
    @(posedge clock);
    @(negedge clock);
    check("valid_not_yet", int'(out_valid), 0);
    @(posedge clock);
    @(negedge clock);
    check("valid_first_rise", int'(out_valid), 1);
    wait_done("scan_3_4");

    // wrap past the top address
    start_scan(30, 4);
    wait_done("scan_wrap");

    // consumer stall
    gap_en = 1'b0;
    out_ready = 1'b0;
    start_scan(10, 2);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clock);
      if (out_valid) seen = 1'b1;
    end
    check("stall_valid_seen", int'(seen), 1);
    hold_d = out_data;
    hold_a = out_addr;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("stall_valid", int'(out_valid), 1);
      check("stall_data", int'(out_data), int'(hold_d));
      check("stall_addr", int'(out_addr), int'(hold_a));
    end
    out_ready = 1'b1;
    wait_done("scan_stall");

    // count zero is ignored
    @(posedge clock);
    #1;
    start = 1'b1;
    count = '0;
    start_addr = AW'(7);
    d0 = done_cnt;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("cnt0_busy", int'(busy), 0);
      check("cnt0_valid", int'(out_valid), 0);
    end
    start = 1'b0;
    check("cnt0_no_done", done_cnt, d0);

    // oversize count clamps to 32 words
    gap_en = 1'b1;
    start_scan(5, 40);
    wait_done("scan_40");

    // start re-asserted mid-scan is ignored
    start_scan(0, 3);
    repeat (4) @(posedge clock);
    #1;
    start = 1'b1;
    start_addr = AW'(20);
    count = (AW+1)'(10);
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_done("scan_restart_ignored");
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (out_valid || busy) seen = 1'b1;
    end
    check("no_second_scan", int'(seen), 0);

    // asynchronous reset during WAIT of the second word
    start_scan(8, 4);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clock);
      if (out_valid) seen = 1'b1;
    end
    check("rst_test_first_word", int'(seen), 1);
    @(posedge clock);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_ram_addr", int'(ram_addr), 0);
    check("mid_rst_out_addr", int'(out_addr), 0);
    check("mid_rst_out_data", int'(out_data), 0);
    exp_q.delete();
    d0 = done_cnt;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("post_rst_idle", int'(busy), 0);
    check("post_rst_no_done", done_cnt, d0);
    start_scan(12, 3);
    wait_done("scan_after_reset");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
